mempool_tcdm_link_buffer: RTL
=============================

Name: mempool_tcdm_link_buffer

Overview:
- Parametrised, multi-channel elastic buffer for the TCDM links between tile/sub-group and group levels.
- Replaces fixed single-entry spill/fall-through stages with configurable-depth request and response FIFOs per channel.
- Adds per-channel outstanding-transaction credit limiting, so the response buffer can never be overrun.
- One instance covers NumChannels independent request/response channel pairs; channels share no state.

Parameters:
NumChannels, 4, number of independent request/response channel pairs
ReqWidth, 64, request payload bits
RespWidth, 40, response payload bits
ReqDepth, 2, request FIFO entries per channel (0 = combinational passthrough)
RespDepth, 2, response FIFO entries per channel (minimum 1)
ReqFallThrough, 0, 1 = request FIFO forwards combinationally when empty; 0 = always registered
MaxOutstanding, 4, max accepted-but-unanswered requests per channel (minimum 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_i  in  [NumChannels][ReqWidth]  upstream request payload
req_valid_i  in  [NumChannels]  upstream request valid
req_ready_o  out  [NumChannels]  upstream request ready
req_o  out  [NumChannels][ReqWidth]  downstream request payload
req_valid_o  out  [NumChannels]  downstream request valid
req_ready_i  in  [NumChannels]  downstream request ready
resp_i  in  [NumChannels][RespWidth]  downstream response payload
resp_valid_i  in  [NumChannels]  downstream response valid
resp_ready_o  out  [NumChannels]  downstream response ready
resp_o  out  [NumChannels][RespWidth]  upstream response payload
resp_valid_o  out  [NumChannels]  upstream response valid
resp_ready_i  in  [NumChannels]  upstream response ready
outstanding_o  out  [NumChannels][$clog2(MaxOutstanding+1)]  per-channel outstanding count

Behaviour:
Interface:
- One clock, clk_i. Reset rst_i is synchronous and active-high; sampled only on the rising edge of clk_i.
- All handshakes are valid/ready. A transfer occurs when valid and ready are both high at a rising edge.
- valid, once raised, must not drop before its transfer.

Reset and ordering:
- Reset clears all FIFO counts, pointers and outstanding counters.
- After reset: req_valid_o=0, resp_valid_o=0, req_o=0, resp_o=0, outstanding_o=0, req_ready_o=1, resp_ready_o=1.
- Reset asserted mid-operation drops all buffered entries and counts in the same edge. No output glitch beyond the combinational paths below.
- Strict FIFO order within a channel; no interaction between channels.

Request path (per channel):
- req_ready_o = !req_full && (outstanding < MaxOutstanding).
- Accepted request increments the outstanding counter.
- ReqDepth=0: req_o=req_i, req_valid_o=req_valid_i && credit_ok, req_ready_o=req_ready_i && credit_ok.
- ReqFallThrough=0: accepted entry appears on req_o/req_valid_o the next cycle (latency 1). req_ready_o has no combinational dependence on req_ready_i.
- ReqFallThrough=1 with FIFO empty: req_i is forwarded combinationally. If req_ready_i=1 the entry is not stored; otherwise it is stored.
- Full FIFO (count==ReqDepth): push blocked even if a pop occurs in the same cycle.
- Not full: simultaneous push and pop leaves the count unchanged.

Response path (per channel):
- Always registered: latency 1 from resp_i transfer to resp_valid_o.
- resp_ready_o = !resp_full.
- Full FIFO: push and pop in the same cycle are not combined; ready stays low for that cycle.

Outstanding counter:
- Increments on an upstream request transfer (req_valid_i && req_ready_o).
- Decrements on an upstream response transfer (resp_valid_o && resp_ready_i).
- Both in the same cycle: unchanged.
- Saturates at 0; never underflows.
- A response transfer while the counter is 0 is a protocol error. Flag it with a simulation assertion; the counter stays 0.
- MaxOutstanding <= RespDepth guarantees the responder is never back-pressured by this block.

Elaboration checks:
- RespDepth>=1.
- MaxOutstanding>=1.
- ReqFallThrough is ignored when ReqDepth=0.

Test Plan:
- Reset, then idle: all valid outputs 0, req_ready_o=4'b1111, resp_ready_o=4'b1111, outstanding_o=0 on every channel.
- Defaults, ch0: send 0xA1, 0xA2 with req_ready_i=0 -> req_ready_o[0] drops after 2 accepts. Raise req_ready_i -> 0xA1 then 0xA2 in order; outstanding_o[0]=2.
- MaxOutstanding=4, RespDepth=4, downstream always ready, no responses returned: 4 requests accepted -> req_ready_o[0]=0, outstanding_o[0]=4. Return one response with resp_ready_i=1 -> count 3 and ready re-asserts the same cycle.
- Simultaneous request accept and response transfer on ch2 with outstanding=2 -> outstanding stays 2. Ch1 activity leaves ch2 untouched.
- ReqFallThrough=1, empty FIFO, req_ready_i=1: 0xB7 appears on req_o in the same cycle. Repeat with ReqDepth=0 -> same, and the request is gated when outstanding=MaxOutstanding.
- Assert rst_i with 2 requests and 1 response buffered -> next cycle all valids 0, outstanding_o=0. Subsequent traffic starts cleanly from empty.

Source files
------------

// File: rtl/mempool_tcdm_link_buffer.sv
// Multi-channel elastic buffer for TCDM request/response links.
// Every channel has its own request FIFO, response FIFO and outstanding-credit
// counter, so the response FIFO of a channel cannot be overrun when
// MaxOutstanding <= RespDepth. Channels share no state.
module mempool_tcdm_link_buffer #(
  parameter int unsigned NumChannels    = 4,
  parameter int unsigned ReqWidth       = 64,
  parameter int unsigned RespWidth      = 40,
  parameter int unsigned ReqDepth       = 2,
  parameter int unsigned RespDepth      = 2,
  parameter bit          ReqFallThrough = 1'b0,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned OutW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumChannels-1:0][ReqWidth-1:0]  req_i,
  input  logic [NumChannels-1:0]                req_valid_i,
  output logic [NumChannels-1:0]                req_ready_o,
  output logic [NumChannels-1:0][ReqWidth-1:0]  req_o,
  output logic [NumChannels-1:0]                req_valid_o,
  input  logic [NumChannels-1:0]                req_ready_i,
  input  logic [NumChannels-1:0][RespWidth-1:0] resp_i,
  input  logic [NumChannels-1:0]                resp_valid_i,
  output logic [NumChannels-1:0]                resp_ready_o,
  output logic [NumChannels-1:0][RespWidth-1:0] resp_o,
  output logic [NumChannels-1:0]                resp_valid_o,
  input  logic [NumChannels-1:0]                resp_ready_i,
  output logic [NumChannels-1:0][OutW-1:0]      outstanding_o
);

  localparam logic [OutW-1:0] MaxOutC = OutW'(MaxOutstanding);
  localparam int unsigned SPtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned SCntW = $clog2(RespDepth + 1);

  if (RespDepth < 1) begin : gen_bad_resp_depth
    $error("RespDepth must be at least 1");
  end
  if (MaxOutstanding < 1) begin : gen_bad_max_outstanding
    $error("MaxOutstanding must be at least 1");
  end

  for (genvar g = 0; g < NumChannels; g++) begin : gen_ch

    logic            creditOk;
    logic            reqAcc;
    logic            respAcc;
    logic [OutW-1:0] outCnt_q, outCnt_d;

    // A new request may only enter while this channel still has credit left.
    assign creditOk = (outCnt_q < MaxOutC);
    assign reqAcc   = req_valid_i[g] && req_ready_o[g];
    assign respAcc  = resp_valid_o[g] && resp_ready_i[g];
    assign outstanding_o[g] = outCnt_q;

    // Credit counter: up on request accept, down on response delivery, clamped at zero.
    always_comb begin
      outCnt_d = outCnt_q;
      if (reqAcc && !respAcc) begin
        outCnt_d = outCnt_q + OutW'(1);
      end else if (respAcc && !reqAcc && (outCnt_q != '0)) begin
        outCnt_d = outCnt_q - OutW'(1);
      end
    end

    // Credit counter register.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        outCnt_q <= '0;
      end else begin
        outCnt_q <= outCnt_d;
      end
    end

    // A response delivered with no request in flight means the responder misbehaved.
    assert property (@(posedge clk_i) disable iff (rst_i) !(respAcc && (outCnt_q == '0)))
      else $error("channel %0d: response delivered with no outstanding request", g);

    // ---------------- request path ----------------
    if (ReqDepth == 0) begin : gen_req_pass
      assign req_o[g]       = req_i[g];
      assign req_valid_o[g] = req_valid_i[g] && creditOk;
      assign req_ready_o[g] = req_ready_i[g] && creditOk;
    end else begin : gen_req_fifo
      localparam int unsigned RPtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
      localparam int unsigned RCntW = $clog2(ReqDepth + 1);

      logic [ReqWidth-1:0] reqMem_q [ReqDepth];
      logic [RPtrW-1:0]    reqWr_q, reqRd_q, reqWrNext, reqRdNext;
      logic [RCntW-1:0]    reqCnt_q, reqCnt_d;
      logic                reqEmpty, reqFull, reqStore, reqPop;

      assign reqEmpty  = (reqCnt_q == '0);
      assign reqFull   = (reqCnt_q == RCntW'(ReqDepth));
      assign reqWrNext = (reqWr_q == RPtrW'(ReqDepth - 1)) ? '0 : reqWr_q + RPtrW'(1);
      assign reqRdNext = (reqRd_q == RPtrW'(ReqDepth - 1)) ? '0 : reqRd_q + RPtrW'(1);

      // Readiness never looks at the downstream ready, so a full FIFO blocks a push even on a pop.
      assign req_ready_o[g] = !reqFull && creditOk;
      assign reqPop         = !reqEmpty && req_ready_i[g];

      if (ReqFallThrough) begin : gen_ft
        // When empty the incoming request is forwarded directly and only stored if not taken.
        assign req_valid_o[g] = reqEmpty ? (req_valid_i[g] && creditOk) : 1'b1;
        assign req_o[g]       = reqEmpty ? req_i[g] : reqMem_q[reqRd_q];
        assign reqStore       = reqAcc && !(reqEmpty && req_ready_i[g]);
      end else begin : gen_reg
        assign req_valid_o[g] = !reqEmpty;
        assign req_o[g]       = reqMem_q[reqRd_q];
        assign reqStore       = reqAcc;
      end

      // Request occupancy: simultaneous store and pop leave it unchanged.
      always_comb begin
        reqCnt_d = reqCnt_q;
        if (reqStore && !reqPop) begin
          reqCnt_d = reqCnt_q + RCntW'(1);
        end else if (reqPop && !reqStore) begin
          reqCnt_d = reqCnt_q - RCntW'(1);
        end
      end

      // Request storage and pointers; storage is cleared so req_o reads zero after reset.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          reqCnt_q <= '0;
          reqWr_q  <= '0;
          reqRd_q  <= '0;
          for (int i = 0; i < ReqDepth; i++) begin
            reqMem_q[i] <= '0;
          end
        end else begin
          if (reqStore) begin
            reqMem_q[reqWr_q] <= req_i[g];
            reqWr_q           <= reqWrNext;
          end
          if (reqPop) begin
            reqRd_q <= reqRdNext;
          end
          reqCnt_q <= reqCnt_d;
        end
      end
    end

    // ---------------- response path ----------------
    logic [RespWidth-1:0] respMem_q [RespDepth];
    logic [SPtrW-1:0]     respWr_q, respRd_q, respWrNext, respRdNext;
    logic [SCntW-1:0]     respCnt_q, respCnt_d;
    logic                 respEmpty, respFull, respPush, respPop;

    assign respEmpty  = (respCnt_q == '0);
    assign respFull   = (respCnt_q == SCntW'(RespDepth));
    assign respWrNext = (respWr_q == SPtrW'(RespDepth - 1)) ? '0 : respWr_q + SPtrW'(1);
    assign respRdNext = (respRd_q == SPtrW'(RespDepth - 1)) ? '0 : respRd_q + SPtrW'(1);

    assign resp_ready_o[g] = !respFull;
    assign resp_valid_o[g] = !respEmpty;
    assign resp_o[g]       = respMem_q[respRd_q];
    assign respPush        = resp_valid_i[g] && !respFull;
    assign respPop         = respAcc;

    // Response occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
      respCnt_d = respCnt_q;
      if (respPush && !respPop) begin
        respCnt_d = respCnt_q + SCntW'(1);
      end else if (respPop && !respPush) begin
        respCnt_d = respCnt_q - SCntW'(1);
      end
    end

    // Response storage and pointers; always registered, so latency is one cycle.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        respCnt_q <= '0;
        respWr_q  <= '0;
        respRd_q  <= '0;
        for (int i = 0; i < RespDepth; i++) begin
          respMem_q[i] <= '0;
        end
      end else begin
        if (respPush) begin
          respMem_q[respWr_q] <= resp_i[g];
          respWr_q            <= respWrNext;
        end
        if (respPop) begin
          respRd_q <= respRdNext;
        end
        respCnt_q <= respCnt_d;
      end
    end
  end

endmodule
